// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: streams a program into the instruction memory over a
// valid/ready port, then sequences the PC with stall, branch and wrap handling.
module instr_fetch_ctrl #(
    parameter int unsigned DATA_W   = 22,
    parameter int unsigned ADDR_W   = 22,
    parameter int unsigned DEPTH    = 101,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_start_i,
    input  logic              run_start_i,
    input  logic              ld_valid_i,
    output logic              ld_ready_o,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic              ld_last_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] instr_o,
    output logic              instr_valid_o,
    output logic              load_done_o,
    output logic              fault_o
);

    localparam int unsigned WPTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ResetPc  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] MemBytes = ADDR_W'(DEPTH * 4);
    localparam logic [WPTR_W-1:0] LastWptr = WPTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StFlush, StRun} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [WPTR_W-1:0]   wptr_q, wptr_d;
    logic                load_done_q, load_done_d;
    logic                fault_q, fault_d;
    logic                beat;
    logic [ADDR_W-1:0]   pc_plus4;
    logic [ADDR_W-1:0]   br_aligned;

    assign ld_ready_o    = (state_q == StLoad);
    assign beat          = ld_ready_o & ld_valid_i;
    assign mem_we_o      = beat;
    assign mem_waddr_o   = ADDR_W'({wptr_q, 2'b00});
    assign mem_wdata_o   = ld_data_i;
    assign mem_raddr_o   = pc_q;
    assign pc_o          = pc_q;
    assign instr_valid_o = (state_q == StRun);
    assign instr_o       = instr_valid_o ? mem_rdata_i : '0;
    assign load_done_o   = load_done_q;
    assign fault_o       = fault_q;

    assign pc_plus4   = pc_q + ADDR_W'(4);
    assign br_aligned = {branch_target_i[ADDR_W-1:2], 2'b00};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        wptr_d      = wptr_q;
        load_done_d = load_done_q;
        fault_d     = fault_q;
        unique case (state_q)
            StIdle: begin
                if (load_start_i) begin
                    state_d     = StLoad;
                    wptr_d      = '0;
                    load_done_d = 1'b0;
                    fault_d     = 1'b0;
                end else if (run_start_i) begin
                    state_d = StFlush;
                end
            end
            StLoad: begin
                if (beat) begin
                    wptr_d = wptr_q + WPTR_W'(1);
                    if (ld_last_i) begin
                        state_d     = StFlush;
                        load_done_d = 1'b1;
                    end else if (wptr_q == LastWptr) begin
                        state_d = StIdle;
                        fault_d = 1'b1;
                    end
                end
            end
            StFlush: begin
                pc_d    = ResetPc;
                state_d = StRun;
            end
            StRun: begin
                if (load_start_i) begin
                    // Abandon the in-flight instruction; PC is reloaded by FLUSH later.
                    state_d     = StLoad;
                    wptr_d      = '0;
                    load_done_d = 1'b0;
                    fault_d     = 1'b0;
                end else if (branch_taken_i) begin
                    if (br_aligned >= MemBytes) begin
                        pc_d    = ResetPc;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = br_aligned;
                    end
                end else if (!stall_i) begin
                    pc_d = (pc_plus4 == MemBytes) ? '0 : pc_plus4;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            pc_q        <= ResetPc;
            wptr_q      <= '0;
            load_done_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wptr_q      <= wptr_d;
            load_done_q <= load_done_d;
            fault_q     <= fault_d;
        end
    end

endmodule
